// File: rtl/mii_rx_framer_if.sv
// Received-byte stream leaving the MII framer.
// Handshake: valid-only. m_valid is a one-cycle strobe qualifying m_data;
// there is no ready because MII cannot stall. m_last qualifies the final
// byte of a frame and is only meaningful with m_valid. m_err and the stat_*
// bits are only meaningful with m_last and are 0 on every other cycle.
interface mii_rx_framer_if;
  logic [7:0] m_data;
  logic       m_valid;
  logic       m_last;
  logic       m_err;
  logic       stat_crc_err;
  logic       stat_short;
  logic       stat_long;
  logic       stat_align;
  logic       stat_rxerr;

  modport master (
    output m_data, m_valid, m_last, m_err,
    output stat_crc_err, stat_short, stat_long, stat_align, stat_rxerr
  );

  modport slave (
    input m_data, m_valid, m_last, m_err,
    input stat_crc_err, stat_short, stat_long, stat_align, stat_rxerr
  );
endinterface

// File: rtl/mii_rx_framer.sv
// MII receive framer: registers the nibble stream, strips preamble/SFD,
// packs nibbles into bytes (low nibble first), holds one byte so the final
// byte can carry frame status, checks FCS residue and length, and counts
// good/bad frames with saturating counters.
module mii_rx_framer #(
  parameter int MIN_FRAME = 64,
  parameter int MAX_FRAME = 1518,
  parameter int CNT_W     = 16
) (
  input  logic             eth_rx_clk,
  input  logic             eth_rx_rst,
  input  logic             eth_rx_dv,
  input  logic [3:0]       eth_rxd,
  input  logic             eth_rxerr,
  mii_rx_framer_if.master  m_if,
  output logic [CNT_W-1:0] frame_ok_count,
  output logic [CNT_W-1:0] frame_bad_count,
  output logic [1:0]       dbg_state
);

  localparam int          CW       = $clog2(MAX_FRAME + 2);
  localparam logic [CW-1:0] MAX_CNT = CW'(MAX_FRAME);
  localparam logic [CW-1:0] MIN_CNT = CW'(MIN_FRAME);
  localparam logic [31:0] CRC_POLY = 32'hEDB88320;
  localparam logic [31:0] CRC_RES  = 32'hDEBB20E3;
  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  typedef enum logic [1:0] {
    S_DROP = 2'd0,
    S_IDLE = 2'd1,
    S_PRE  = 2'd2,
    S_DATA = 2'd3
  } state_t;

  // One byte of reflected CRC-32, bit-serial unrolled over eight steps.
  function automatic logic [31:0] crc_byte(input logic [31:0] c, input logic [7:0] b);
    logic [31:0] r;
    r = c ^ {24'h0, b};
    for (int i = 0; i < 8; i++) begin
      r = r[0] ? ((r >> 1) ^ CRC_POLY) : (r >> 1);
    end
    return r;
  endfunction

  logic       dv_q;
  logic [3:0] rxd_q;
  logic       er_q;

  state_t          state_q, state_d;
  logic            phase_q, phase_d;
  logic [3:0]      low_q, low_d;
  logic [7:0]      held_q, held_d;
  logic [31:0]     crc_q, crc_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic            rxerr_q, rxerr_d;

  logic [7:0]      data_q, data_d;
  logic            valid_q, valid_d;
  logic            last_q, last_d;
  logic            crc_err_q, crc_err_d;
  logic            short_q, short_d;
  logic            long_q, long_d;
  logic            align_q, align_d;
  logic            serr_q, serr_d;
  logic [CNT_W-1:0] ok_cnt_q, ok_cnt_d;
  logic [CNT_W-1:0] bad_cnt_q, bad_cnt_d;

  logic [7:0]      byte_w;
  logic            err_d;

  // Input pipeline stage. Left out of reset on purpose: a reset taken
  // mid-frame still sees dv high afterwards and parks in DROP.
  always_ff @(posedge eth_rx_clk) begin
    dv_q  <= eth_rx_dv;
    rxd_q <= eth_rxd;
    er_q  <= eth_rxerr;
  end

  // State, assembly and output registers.
  always_ff @(posedge eth_rx_clk) begin
    if (eth_rx_rst) begin
      state_q   <= S_DROP;
      phase_q   <= 1'b0;
      low_q     <= 4'h0;
      held_q    <= 8'h00;
      crc_q     <= 32'hFFFF_FFFF;
      cnt_q     <= '0;
      rxerr_q   <= 1'b0;
      data_q    <= 8'h00;
      valid_q   <= 1'b0;
      last_q    <= 1'b0;
      crc_err_q <= 1'b0;
      short_q   <= 1'b0;
      long_q    <= 1'b0;
      align_q   <= 1'b0;
      serr_q    <= 1'b0;
      ok_cnt_q  <= '0;
      bad_cnt_q <= '0;
    end else begin
      state_q   <= state_d;
      phase_q   <= phase_d;
      low_q     <= low_d;
      held_q    <= held_d;
      crc_q     <= crc_d;
      cnt_q     <= cnt_d;
      rxerr_q   <= rxerr_d;
      data_q    <= data_d;
      valid_q   <= valid_d;
      last_q    <= last_d;
      crc_err_q <= crc_err_d;
      short_q   <= short_d;
      long_q    <= long_d;
      align_q   <= align_d;
      serr_q    <= serr_d;
      ok_cnt_q  <= ok_cnt_d;
      bad_cnt_q <= bad_cnt_d;
    end
  end

  // Next-state, byte assembly, status and counter logic.
  always_comb begin
    state_d   = state_q;
    phase_d   = phase_q;
    low_d     = low_q;
    held_d    = held_q;
    crc_d     = crc_q;
    cnt_d     = cnt_q;
    rxerr_d   = rxerr_q;
    data_d    = data_q;
    valid_d   = 1'b0;
    last_d    = 1'b0;
    crc_err_d = 1'b0;
    short_d   = 1'b0;
    long_d    = 1'b0;
    align_d   = 1'b0;
    serr_d    = 1'b0;
    ok_cnt_d  = ok_cnt_q;
    bad_cnt_d = bad_cnt_q;
    byte_w    = {rxd_q, low_q};

    case (state_q)
      S_DROP: begin
        if (!dv_q) state_d = S_IDLE;
      end
      S_IDLE: begin
        if (dv_q) state_d = (rxd_q == 4'h5) ? S_PRE : S_DROP;
      end
      S_PRE: begin
        if (!dv_q) begin
          state_d = S_IDLE;
        end else if (rxd_q == 4'hD) begin
          state_d = S_DATA;
          phase_d = 1'b0;
          crc_d   = 32'hFFFF_FFFF;
          cnt_d   = '0;
          rxerr_d = er_q;
        end else if (rxd_q != 4'h5) begin
          state_d = S_DROP;
        end
      end
      S_DATA: begin
        if (!dv_q) begin
          // Frame end: flush the held byte with its status, if any byte exists.
          state_d = S_IDLE;
          if (cnt_q != '0) begin
            valid_d   = 1'b1;
            last_d    = 1'b1;
            data_d    = held_q;
            crc_err_d = (crc_q != CRC_RES);
            short_d   = (cnt_q < MIN_CNT);
            align_d   = phase_q;
            serr_d    = rxerr_q;
          end
        end else begin
          rxerr_d = rxerr_q | er_q;
          if (!phase_q) begin
            low_d   = rxd_q;
            phase_d = 1'b1;
          end else begin
            phase_d = 1'b0;
            if (cnt_q == MAX_CNT) begin
              // Byte MAX_FRAME+1 arrived: close the frame as truncated.
              valid_d = 1'b1;
              last_d  = 1'b1;
              data_d  = held_q;
              long_d  = 1'b1;
              serr_d  = rxerr_q | er_q;
              state_d = S_DROP;
            end else begin
              crc_d  = crc_byte(crc_q, byte_w);
              cnt_d  = cnt_q + CW'(1);
              held_d = byte_w;
              if (cnt_q != '0) begin
                valid_d = 1'b1;
                data_d  = held_q;
              end
            end
          end
        end
      end
      default: state_d = S_DROP;
    endcase

    err_d = crc_err_d | short_d | long_d | align_d | serr_d;
    if (last_d) begin
      if (err_d) begin
        if (bad_cnt_q != CNT_MAX) bad_cnt_d = bad_cnt_q + CNT_W'(1);
      end else begin
        if (ok_cnt_q != CNT_MAX) ok_cnt_d = ok_cnt_q + CNT_W'(1);
      end
    end
  end

  assign m_if.m_data       = data_q;
  assign m_if.m_valid      = valid_q;
  assign m_if.m_last       = last_q;
  assign m_if.stat_crc_err = crc_err_q;
  assign m_if.stat_short   = short_q;
  assign m_if.stat_long    = long_q;
  assign m_if.stat_align   = align_q;
  assign m_if.stat_rxerr   = serr_q;
  assign m_if.m_err        = crc_err_q | short_q | long_q | align_q | serr_q;
  assign frame_ok_count    = ok_cnt_q;
  assign frame_bad_count   = bad_cnt_q;
  assign dbg_state         = state_q;

endmodule

// File: tb/tb_mii_rx_framer.sv
// Bench for mii_rx_framer: directed frames from the test plan followed by
// randomized frames, checked against a frame-level reference model.
module tb_mii_rx_framer;
  localparam int MIN_FRAME = 64;
  localparam int MAX_FRAME = 1518;
  localparam int CNT_W     = 3;
  localparam int SAT       = (1 << CNT_W) - 1;

  // Clock and reset
  logic clk = 1'b0;
  always #20 clk = ~clk;

  logic             rst;
  logic             dv;
  logic [3:0]       rxd;
  logic             er;
  logic [CNT_W-1:0] ok_count;
  logic [CNT_W-1:0] bad_count;
  logic [1:0]       dbg_state;

  mii_rx_framer_if m_if();

  mii_rx_framer #(
    .MIN_FRAME(MIN_FRAME),
    .MAX_FRAME(MAX_FRAME),
    .CNT_W(CNT_W)
  ) dut (
    .eth_rx_clk      (clk),
    .eth_rx_rst      (rst),
    .eth_rx_dv       (dv),
    .eth_rxd         (rxd),
    .eth_rxerr       (er),
    .m_if            (m_if.master),
    .frame_ok_count  (ok_count),
    .frame_bad_count (bad_count),
    .dbg_state       (dbg_state)
  );

  // Scoreboard state
  int n_checks = 0;
  int n_errors = 0;
  logic [8:0] exp_q[$];        // {last, data}
  logic [5:0] exp_flag_q[$];   // {err, crc, short, long, align, rxerr}
  logic [7:0] frame_q[$];      // frame bytes DA..FCS to drive
  int model_ok  = 0;
  int model_bad = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Ethernet FCS value (inverted CRC-32) over the first nbytes of frame_q.
  function automatic logic [31:0] fcs_of(input int nbytes);
    logic [31:0] c;
    c = 32'hFFFF_FFFF;
    for (int i = 0; i < nbytes; i++) begin
      c = c ^ {24'h0, frame_q[i]};
      for (int k = 0; k < 8; k++) c = c[0] ? ((c >> 1) ^ 32'hEDB88320) : (c >> 1);
    end
    return ~c;
  endfunction

  task automatic append_fcs();
    logic [31:0] f;
    f = fcs_of(frame_q.size());
    frame_q.push_back(f[7:0]);
    frame_q.push_back(f[15:8]);
    frame_q.push_back(f[23:16]);
    frame_q.push_back(f[31:24]);
  endtask

  task automatic build_seq(input int n);
    frame_q.delete();
    for (int i = 0; i < n; i++) frame_q.push_back(8'(i));
  endtask

  task automatic build_rand(input int n);
    frame_q.delete();
    for (int i = 0; i < n; i++) frame_q.push_back(8'($urandom_range(0, 255)));
  endtask

  // Reference model: expected byte stream, final status and counters.
  task automatic model_frame(input bit extra, input int err_nib, input int rst_byte);
    int n, keep;
    logic [31:0] fcs_rx;
    logic c_err, s_short, s_long, s_align, s_rxerr, any_err;
    n = frame_q.size();
    if (rst_byte >= 0) begin
      // The byte that would be released on the reset edge is lost, so only
      // bytes before rst_byte-2 come out; the reset also clears the counters.
      for (int i = 0; i < rst_byte - 2; i++) exp_q.push_back({1'b0, frame_q[i]});
      model_ok  = 0;
      model_bad = 0;
      return;
    end
    if (n == 0) return;
    keep = (n > MAX_FRAME) ? MAX_FRAME : n;
    for (int i = 0; i < keep; i++) exp_q.push_back({1'(i == keep - 1), frame_q[i]});
    s_long = (n > MAX_FRAME);
    if (s_long) begin
      c_err = 1'b0; s_short = 1'b0; s_align = 1'b0;
      s_rxerr = (err_nib >= 0);
    end else begin
      if (n >= 4) begin
        fcs_rx = {frame_q[n-1], frame_q[n-2], frame_q[n-3], frame_q[n-4]};
        c_err  = (fcs_rx != fcs_of(n - 4));
      end else begin
        c_err = 1'b1;
      end
      s_short = (n < MIN_FRAME);
      s_align = extra;
      s_rxerr = (err_nib >= 0) && (err_nib < 2 * n + int'(extra));
    end
    any_err = c_err | s_short | s_long | s_align | s_rxerr;
    exp_flag_q.push_back({any_err, c_err, s_short, s_long, s_align, s_rxerr});
    if (any_err) model_bad = (model_bad < SAT) ? model_bad + 1 : SAT;
    else         model_ok  = (model_ok  < SAT) ? model_ok  + 1 : SAT;
  endtask

  // Driver tasks
  task automatic idle(input int n);
    repeat (n) begin
      @(negedge clk);
      rst = 1'b0; dv = 1'b0; rxd = 4'h0; er = 1'b0;
    end
  endtask

  task automatic drive_nib(input logic [3:0] d, input bit e, input bit r);
    @(negedge clk);
    rst = r; dv = 1'b1; rxd = d; er = e;
  endtask

  task automatic send_frame(input bit extra, input int err_nib, input int rst_byte);
    logic [7:0] b;
    for (int i = 0; i < 7; i++) begin
      drive_nib(4'h5, 1'b0, 1'b0);
      drive_nib(4'h5, 1'b0, 1'b0);
    end
    drive_nib(4'h5, 1'b0, 1'b0);
    drive_nib(4'hD, 1'b0, 1'b0);
    for (int i = 0; i < frame_q.size(); i++) begin
      b = frame_q[i];
      drive_nib(b[3:0], (2 * i) == err_nib, i == rst_byte);
      drive_nib(b[7:4], (2 * i + 1) == err_nib, 1'b0);
    end
    if (extra) drive_nib(4'($urandom_range(0, 15)), (2 * frame_q.size()) == err_nib, 1'b0);
  endtask

  task automatic run_frame(input bit extra, input int err_nib, input int rst_byte, input int ifg);
    model_frame(extra, err_nib, rst_byte);
    send_frame(extra, err_nib, rst_byte);
    idle(ifg);
  endtask

  task automatic settle_and_check(input string tag);
    idle(6);
    check({tag, "_drained"}, 32'(exp_q.size()), 32'd0);
    check({tag, "_flags_drained"}, 32'(exp_flag_q.size()), 32'd0);
    check({tag, "_ok_count"}, 32'(ok_count), 32'(model_ok));
    check({tag, "_bad_count"}, 32'(bad_count), 32'(model_bad));
    exp_q.delete();
    exp_flag_q.delete();
  endtask

  // Monitor: compare every strobe against the expected queue.
  logic [8:0] e_byte;
  logic [5:0] obs_flags;
  always @(negedge clk) begin
    obs_flags = {m_if.m_err, m_if.stat_crc_err, m_if.stat_short, m_if.stat_long,
                 m_if.stat_align, m_if.stat_rxerr};
    if (m_if.m_valid === 1'b1) begin
      if (exp_q.size() == 0) begin
        check("unexpected_strobe", 32'd1, 32'd0);
      end else begin
        e_byte = exp_q.pop_front();
        check("m_data", 32'(m_if.m_data), 32'(e_byte[7:0]));
        check("m_last", 32'(m_if.m_last), 32'(e_byte[8]));
        if (e_byte[8]) begin
          if (exp_flag_q.size() == 0) check("missing_flags", 32'd1, 32'd0);
          else check("status", 32'(obs_flags), 32'(exp_flag_q.pop_front()));
        end else begin
          check("status_mid_frame", 32'(obs_flags), 32'd0);
        end
      end
    end else if (m_if.m_valid === 1'b0) begin
      check("idle_pulses", 32'({m_if.m_last, obs_flags}), 32'd0);
    end else begin
      check("m_valid_known", 32'(m_if.m_valid), 32'd0);
    end
  end

  // Stimulus
  initial begin
    int len, err_nib, kind;
    bit extra;
    rst = 1'b1; dv = 1'b0; rxd = 4'h0; er = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_m_valid", 32'(m_if.m_valid), 32'd0);
    check("rst_m_data", 32'(m_if.m_data), 32'd0);
    check("rst_ok_count", 32'(ok_count), 32'd0);
    check("rst_bad_count", 32'(bad_count), 32'd0);
    idle(4);

    // Good 64-byte frame
    build_seq(60); append_fcs();
    run_frame(1'b0, -1, -1, 12);
    settle_and_check("good");

    // FCS error: payload byte 10 bit 0 flipped after FCS computed
    build_seq(60); append_fcs(); frame_q[10] = frame_q[10] ^ 8'h01;
    run_frame(1'b0, -1, -1, 12);
    settle_and_check("crc_err");

    // Short frame, 40 bytes with valid FCS
    build_seq(36); append_fcs();
    run_frame(1'b0, -1, -1, 12);
    settle_and_check("short");

    // Dribble nibble on an otherwise good frame
    build_seq(60); append_fcs();
    run_frame(1'b1, -1, -1, 12);
    settle_and_check("align");

    // Oversize stream, truncated at MAX_FRAME
    build_rand(1600);
    run_frame(1'b0, -1, -1, 12);
    settle_and_check("long");

    // eth_rxerr for one nibble mid-payload on a good-FCS frame
    build_seq(60); append_fcs();
    run_frame(1'b0, 41, -1, 12);
    settle_and_check("rxerr");

    // Reset at byte 30 with dv held, then a normal frame
    build_seq(60); append_fcs();
    run_frame(1'b0, -1, 30, 12);
    settle_and_check("mid_reset");

    // Two good frames one IFG cycle apart
    build_rand(80); append_fcs();
    run_frame(1'b0, -1, -1, 1);
    build_rand(60); append_fcs();
    run_frame(1'b0, -1, -1, 12);
    settle_and_check("back_to_back");
    check("back_to_back_ok2", 32'(ok_count), 32'd2);

    // Random frames; counters saturate along the way
    for (int it = 0; it < 40; it++) begin
      kind  = $urandom_range(0, 9);
      extra = ($urandom_range(0, 4) == 0);
      if (kind == 0) begin
        build_rand($urandom_range(0, 3));
      end else begin
        build_rand($urandom_range(30, 120));
        append_fcs();
        if ($urandom_range(0, 3) == 0) begin
          len = $urandom_range(0, frame_q.size() - 1);
          frame_q[len] = frame_q[len] ^ 8'(1 << $urandom_range(0, 7));
        end
      end
      err_nib = ($urandom_range(0, 4) == 0 && frame_q.size() > 0) ?
                $urandom_range(0, 2 * frame_q.size() - 1) : -1;
      run_frame(extra, err_nib, -1, $urandom_range(1, 6));
      settle_and_check("random");
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/mii_rx_framer.md
Name: mii_rx_framer

Overview:
- Receive-side MII framing stage, clocked by eth_rx_clk, sitting directly downstream of the PHY MII receive pins.
- Registers the 4-bit MII receive stream, detects preamble/SFD, and assembles nibbles into bytes, low nibble first.
- Emits a byte stream with frame-end and error flags, checks CRC-32 and frame length, and keeps good/bad frame counters for LED/debug logic.
- Output is valid-only with no backpressure, since MII cannot stall.

Parameters:
MIN_FRAME, 64, minimum legal frame length in bytes (DA through FCS inclusive)
MAX_FRAME, 1518, maximum legal frame length in bytes (DA through FCS inclusive)
CNT_W, 16, width of the frame counters

Ports:
eth_rx_clk  in  1  PHY receive clock (25 MHz at 100 Mb/s); the only clock
eth_rx_rst  in  1  synchronous, active-high reset
eth_rx_dv  in  1  MII receive data valid
eth_rxd  in  4  MII receive nibble
eth_rxerr  in  1  MII receive error
m_data  out  8  received byte
m_valid  out  1  one-cycle strobe, m_data valid
m_last  out  1  with m_valid: final byte of frame
m_err  out  1  with m_last: frame bad (OR of stat_* bits)
stat_crc_err  out  1  with m_last: FCS mismatch
stat_short  out  1  with m_last: length < MIN_FRAME
stat_long  out  1  with m_last: length > MAX_FRAME (truncated)
stat_align  out  1  with m_last: odd nibble count after SFD
stat_rxerr  out  1  with m_last: eth_rxerr seen during frame
frame_ok_count  out  CNT_W  frames ending with m_err=0, saturating
frame_bad_count  out  CNT_W  frames ending with m_err=1, saturating

Behaviour:
- Input register: eth_rx_dv, eth_rxd and eth_rxerr are registered once (dv_q, rxd_q, er_q). All decisions below use the registered values.
- Reset:
  - All outputs and counters go to 0 on the next edge.
  - The state machine goes to DROP.
  - A frame in progress is discarded with no m_last emitted.
- DROP: stay while dv_q=1; go to IDLE when dv_q=0. This guarantees a frame is never entered mid-stream after reset or after an error.
- IDLE:
  - dv_q=1 and rxd_q=0x5 -> PREAMBLE.
  - dv_q=1 with any other nibble -> DROP.
- PREAMBLE:
  - rxd_q=0x5 -> stay.
  - rxd_q=0xD -> DATA, with nibble phase=0, CRC=0xFFFFFFFF, byte count=0, sticky flags cleared.
  - Any other nibble -> DROP.
  - dv_q=0 -> IDLE.
  - No frame output is produced from PREAMBLE.
- DATA, nibble assembly:
  - Phase 0 stores rxd_q as the low nibble.
  - Phase 1 completes byte {rxd_q, low}.
  - Each completed byte updates the CRC (reflected polynomial 0xEDB88320, one byte per cycle) and increments the byte count.
- One-byte hold:
  - A completed byte is held, not emitted.
  - When the next byte completes, the held byte is emitted (m_valid=1, m_last=0) and the new byte takes its place.
  - Latency: byte N appears the cycle after the second nibble of byte N+1 is in rxd_q.
- End of frame (dv_q=0 while in DATA):
  - Next cycle: emit the held byte with m_last=1 and all stat_* bits valid, then return to IDLE.
  - If phase=1 when dv_q falls, set stat_align and discard the partial nibble.
- If dv_q falls before any byte completes: no output, no counter change, return to IDLE.
- CRC check: the CRC runs over all bytes including the FCS; a good frame leaves the residue 0xDEBB20E3. Any other value sets stat_crc_err.
- Length check: the byte count includes the FCS; count < MIN_FRAME sets stat_short.
- Overflow:
  - When the byte count would exceed MAX_FRAME, emit the held byte (byte MAX_FRAME) with m_last=1, stat_long=1 and stat_crc_err=0.
  - Then go to DROP; remaining bytes are discarded.
- stat_rxerr: set if er_q=1 in any cycle from SFD through the end of frame.
- m_err equals the OR of all stat_* bits.
- Counters:
  - Exactly one counter increments per m_last.
  - Both counters saturate at 2^CNT_W-1 with no wrap.
- Outputs:
  - m_valid, m_last and all status bits are single-cycle pulses; 0 otherwise.
  - m_data holds its last value between strobes.
- Back-to-back frames with the minimum IFG (dv_q low for 1 cycle) must be accepted; the m_last of frame A precedes any byte of frame B.

Test Plan:
- Good frame: 7×0x55 preamble + 0xD5 SFD, 60 bytes 0x00..0x3B plus correct FCS -> 64 m_valid pulses, first m_data=0x00, m_last on the 64th, m_err=0, frame_ok_count=1.
- Same frame with payload byte 10 bit 0 flipped -> m_last with stat_crc_err=1, m_err=1, frame_bad_count=1, frame_ok_count unchanged.
- 40-byte frame with valid FCS -> 40 strobes, stat_short=1. Separately, one extra nibble before dv falls -> stat_align=1.
- 1600-byte stream -> exactly 1518 strobes, last with stat_long=1; no output until dv low, then preamble.
- eth_rxerr pulsed 1 cycle mid-payload on a good-FCS frame -> stat_rxerr=1, m_err=1.
- eth_rx_rst asserted for 1 cycle at byte 30 with dv held -> no m_last for that frame; the rest of the frame is ignored; the next full frame is received normally. Two good frames 1 IFG cycle apart -> frame_ok_count=2.
